dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port, 64-word data memory between requester 0 (core load/store unit) and requester 1 (DMA/debug). Each cycle it grants at most one valid request, drives the memory's MemRead/MemWrite/read_address/Write_data, and returns a registered response. It supports a lock for atomic read-modify-write sequences, with a timeout, and reports misaligned or out-of-range accesses. It sits between the requesters and the data memory in the top-level datapath.

---
 rtl/dmem_arb_pkg.sv | 22 ++
 rtl/dmem_rr_pick.sv | 25 ++
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types, defaults and helpers for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    typedef logic port_idx_t;

    localparam int unsigned DEF_DEPTH    = 64;
    localparam int unsigned DEF_LOCK_MAX = 8;

    // Byte address is misaligned or its word index falls outside the memory.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        logic [31:0] word_idx;
        word_idx = {2'b00, addr[31:2]};
        return (addr[1:0] != 2'b00) || (word_idx >= depth);
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin picker; the mask restricts which ports may be granted.
module dmem_rr_pick
    import dmem_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  port_idx_t  last_grant,
    input  logic [1:0] mask,
    output logic [1:0] grant
);

    logic [1:0] req;

    // One-hot grant; on a tie the port that did not win last time goes first.
    always_comb begin
        req   = valid & mask;
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == 1'b1) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core LSU (port 0) and DMA/debug (port 1).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned LOCK_MAX = DEF_LOCK_MAX
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic              req0_lock,
    input  logic [31:0]       req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,

    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic              req1_lock,
    input  logic [31:0]       req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,

    output logic              mem_MemRead,
    output logic              mem_MemWrite,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              lock_timeout
);

    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_t        state;
    port_idx_t         last_grant;
    logic [CNT_W-1:0]  idle_cnt;

    logic [1:0]        valid_vec;
    logic [1:0]        mask;
    logic [1:0]        grant;
    logic              xfer;
    port_idx_t         sel;
    logic              sel_write;
    logic              sel_lock;
    logic [31:0]       sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_err;
    logic              hold_lock;

    // Eligible ports: both in ARB, only the owner in LOCK, none in reset or the timeout cycle.
    always_comb begin
        valid_vec = {req1_valid, req0_valid};
        mask      = 2'b00;
        if (reset && !lock_timeout) begin
            case (state)
                ARB:     mask = 2'b11;
                LOCK0:   mask = 2'b01;
                LOCK1:   mask = 2'b10;
                default: mask = 2'b00;
            endcase
        end
    end

    dmem_rr_pick u_pick (
        .valid      (valid_vec),
        .last_grant (last_grant),
        .mask       (mask),
        .grant      (grant)
    );

    // Steer the granted request onto the memory port and the ready lines.
    always_comb begin
        xfer       = |grant;
        sel        = port_idx_t'(grant[1]);
        sel_write  = sel ? req1_write : req0_write;
        sel_lock   = sel ? req1_lock  : req0_lock;
        sel_addr   = sel ? req1_addr  : req0_addr;
        sel_wdata  = sel ? req1_wdata : req0_wdata;
        sel_err    = addr_err(sel_addr, DEPTH);
        hold_lock  = sel_lock && !sel_err;

        req0_ready   = grant[0];
        req1_ready   = grant[1];
        mem_MemRead  = xfer && !sel_err && !sel_write;
        mem_MemWrite = xfer && !sel_err && sel_write;
        mem_addr     = xfer ? {2'b00, sel_addr[31:2]} : 32'd0;
        mem_wdata    = xfer ? sel_wdata : '0;
    end

    // Lock FSM, idle counter, timeout pulse and round-robin history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ARB;
            idle_cnt     <= '0;
            lock_timeout <= 1'b0;
            last_grant   <= 1'b1;
        end else begin
            lock_timeout <= 1'b0;
            if (xfer) begin
                last_grant <= sel;
            end
            case (state)
                ARB: begin
                    idle_cnt <= '0;
                    if (xfer && hold_lock) begin
                        state <= sel ? LOCK1 : LOCK0;
                    end
                end
                LOCK0, LOCK1: begin
                    if (xfer) begin
                        idle_cnt <= '0;
                        if (!hold_lock) begin
                            state <= ARB;
                        end
                    end else if (idle_cnt == CNT_W'(LOCK_MAX - 1)) begin
                        state        <= ARB;
                        idle_cnt     <= '0;
                        lock_timeout <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= ARB;
                    idle_cnt <= '0;
                end
            endcase
        end
    end

    // One-cycle response per accepted request; load data captured at the accepting edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp0_valid <= 1'b0;
            rsp0_err   <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_valid <= 1'b0;
            rsp1_err   <= 1'b0;
            rsp1_rdata <= '0;
        end else begin
            rsp0_valid <= grant[0];
            rsp0_err   <= grant[0] && sel_err;
            rsp0_rdata <= (grant[0] && mem_MemRead) ? mem_rdata : '0;
            rsp1_valid <= grant[1];
            rsp1_err   <= grant[1] && sel_err;
            rsp1_rdata <= (grant[1] && mem_MemRead) ? mem_rdata : '0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 64-word memory behind it.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_write, req0_lock;
    logic [31:0] req0_addr, req0_wdata;
    logic        req0_ready, rsp0_valid, rsp0_err;
    logic [31:0] rsp0_rdata;
    logic        req1_valid, req1_write, req1_lock;
    logic [31:0] req1_addr, req1_wdata;
    logic        req1_ready, rsp1_valid, rsp1_err;
    logic [31:0] rsp1_rdata;
    logic        mem_MemRead, mem_MemWrite;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        lock_timeout;

    logic [31:0] mem_q [64];
    logic [63:0] written;
    logic        mem_clr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_write   (req0_write),
        .req0_lock    (req0_lock),
        .req0_addr    (req0_addr),
        .req0_wdata   (req0_wdata),
        .req0_ready   (req0_ready),
        .rsp0_valid   (rsp0_valid),
        .rsp0_rdata   (rsp0_rdata),
        .rsp0_err     (rsp0_err),
        .req1_valid   (req1_valid),
        .req1_write   (req1_write),
        .req1_lock    (req1_lock),
        .req1_addr    (req1_addr),
        .req1_wdata   (req1_wdata),
        .req1_ready   (req1_ready),
        .rsp1_valid   (rsp1_valid),
        .rsp1_rdata   (rsp1_rdata),
        .rsp1_err     (rsp1_err),
        .mem_MemRead  (mem_MemRead),
        .mem_MemWrite (mem_MemWrite),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .lock_timeout (lock_timeout)
    );

    // Memory model: unwritten word i reads 0x1000+i; read is combinational.
    always @(posedge clk) begin
        if (mem_clr) begin
            written <= '0;
        end else if (mem_MemWrite && mem_addr < 32'd64) begin
            mem_q[mem_addr[5:0]]   <= mem_wdata;
            written[mem_addr[5:0]] <= 1'b1;
        end
    end

    always_comb begin
        if (mem_addr >= 32'd64)
            mem_rdata = 32'd0;
        else if (written[mem_addr[5:0]])
            mem_rdata = mem_q[mem_addr[5:0]];
        else
            mem_rdata = 32'h1000 + mem_addr;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic w, input logic l,
                          input logic [31:0] a, input logic [31:0] d);
        req0_valid = v; req0_write = w; req0_lock = l; req0_addr = a; req0_wdata = d;
    endtask

    task automatic drive1(input logic v, input logic w, input logic l,
                          input logic [31:0] a, input logic [31:0] d);
        req1_valid = v; req1_write = w; req1_lock = l; req1_addr = a; req1_wdata = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        reset   = 1'b0;
        mem_clr = 1'b1;
        drive0(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;

        // Reset: everything quiet even with a request pending.
        check("rst_ready0",   32'(req0_ready),   32'd0);
        check("rst_memread",  32'(mem_MemRead),  32'd0);
        check("rst_memaddr",  mem_addr,          32'd0);
        check("rst_rsp0",     32'(rsp0_valid),   32'd0);
        check("rst_timeout",  32'(lock_timeout), 32'd0);
        req0_valid = 1'b0;
        @(negedge clk);
        reset   = 1'b1;
        mem_clr = 1'b0;
        step();

        // Store then load through the other port.
        drive0(1'b1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
        #1;
        check("st_ready0",   32'(req0_ready),   32'd1);
        check("st_memwrite", 32'(mem_MemWrite), 32'd1);
        check("st_memread",  32'(mem_MemRead),  32'd0);
        check("st_memaddr",  mem_addr,          32'd4);
        check("st_wdata",    mem_wdata,         32'hDEADBEEF);
        step();
        drive0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive1(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        #1;
        check("st_rsp0_valid", 32'(rsp0_valid), 32'd1);
        check("st_rsp0_rdata", rsp0_rdata,      32'd0);
        check("st_rsp0_err",   32'(rsp0_err),   32'd0);
        check("ld_ready1",     32'(req1_ready), 32'd1);
        check("ld_memread",    32'(mem_MemRead), 32'd1);
        step();
        drive1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("ld_rsp1_valid", 32'(rsp1_valid), 32'd1);
        check("ld_rsp1_rdata", rsp1_rdata,      32'hDEADBEEF);
        check("ld_rsp0_idle",  32'(rsp0_valid), 32'd0);
        step();
        check("rsp1_pulse",    32'(rsp1_valid), 32'd0);

        // Both ports load every cycle: grants alternate starting with port 0.
        drive0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        drive1(1'b1, 1'b0, 1'b0, 32'h14, 32'h0);
        for (int i = 0; i < 4; i++) begin
            logic exp0;
            exp0 = (i % 2 == 0);
            #1;
            check("rr_ready0", 32'(req0_ready), 32'(exp0));
            check("rr_ready1", 32'(req1_ready), 32'(!exp0));
            step();
            check("rr_rsp0", 32'(rsp0_valid), 32'(exp0));
            check("rr_rsp1", 32'(rsp1_valid), 32'(!exp0));
            if (exp0) check("rr_rdata0", rsp0_rdata, 32'hDEADBEEF);
            else      check("rr_rdata1", rsp1_rdata, 32'h00001005);
        end
        drive0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();

        // Locked read-modify-write holds off port 1.
        drive1(1'b1, 1'b0, 1'b0, 32'h14, 32'h0);
        drive0(1'b1, 1'b0, 1'b1, 32'h20, 32'h0);
        #1;
        check("lk_ready0_a", 32'(req0_ready), 32'd1);
        check("lk_ready1_a", 32'(req1_ready), 32'd0);
        step();
        check("lk_rdata0", rsp0_rdata, 32'h00001008);
        drive0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("lk_ready1_idle", 32'(req1_ready), 32'd0);
        step();
        drive0(1'b1, 1'b1, 1'b1, 32'h20, 32'h0000A5A5);
        #1;
        check("lk_ready0_b", 32'(req0_ready), 32'd1);
        check("lk_ready1_b", 32'(req1_ready), 32'd0);
        step();
        drive0(1'b1, 1'b1, 1'b0, 32'h24, 32'h00005A5A);
        #1;
        check("lk_ready0_c", 32'(req0_ready), 32'd1);
        check("lk_ready1_c", 32'(req1_ready), 32'd0);
        step();
        drive0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive1(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        #1;
        check("lk_ready1_rel", 32'(req1_ready), 32'd1);
        step();
        check("lk_rsp1_rdata", rsp1_rdata, 32'h0000A5A5);

        // Lock left idle times out; port 1 waits one more cycle.
        drive0(1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
        #1;
        check("to_ready0", 32'(req0_ready), 32'd1);
        step();
        drive0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            #1;
            check("to_wait_ready1", 32'(req1_ready),   32'd0);
            check("to_wait_pulse",  32'(lock_timeout), 32'd0);
            step();
        end
        check("to_pulse",        32'(lock_timeout), 32'd1);
        check("to_pulse_ready1", 32'(req1_ready),   32'd0);
        step();
        check("to_pulse_end",    32'(lock_timeout), 32'd0);
        check("to_ready1",       32'(req1_ready),   32'd1);
        step();
        drive1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();

        // Misaligned and out-of-range accesses.
        drive1(1'b1, 1'b0, 1'b0, 32'h102, 32'h0);
        #1;
        check("mis_ready1",  32'(req1_ready), 32'd1);
        check("mis_strobe",  32'({mem_MemRead, mem_MemWrite}), 32'd0);
        step();
        drive1(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        check("mis_err",     32'(rsp1_err),   32'd1);
        check("mis_rdata",   rsp1_rdata,      32'd0);
        #1;
        check("oor_ready1",  32'(req1_ready), 32'd1);
        check("oor_strobe",  32'({mem_MemRead, mem_MemWrite}), 32'd0);
        step();
        drive1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("oor_err",     32'(rsp1_err),   32'd1);
        check("oor_rdata",   rsp1_rdata,      32'd0);
        check("oor_valid",   32'(rsp1_valid), 32'd1);
        step();

        // Reset in LOCK0 with a response pending; port 0 wins the first tie after.
        drive0(1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
        drive1(1'b1, 1'b0, 1'b0, 32'h14, 32'h0);
        #1;
        check("mr_ready0", 32'(req0_ready), 32'd1);
        step();
        check("mr_pending", 32'(rsp0_valid), 32'd1);
        reset = 1'b0;
        #1;
        check("mr_rsp0",    32'(rsp0_valid), 32'd0);
        check("mr_rdata0",  rsp0_rdata,      32'd0);
        check("mr_ready0r", 32'(req0_ready), 32'd0);
        check("mr_ready1r", 32'(req1_ready), 32'd0);
        check("mr_memread", 32'(mem_MemRead), 32'd0);
        @(negedge clk);
        req0_lock = 1'b0;
        reset     = 1'b1;
        #1;
        check("mr_tie0", 32'(req0_ready), 32'd1);
        check("mr_tie1", 32'(req1_ready), 32'd0);
        step();
        check("mr_tie_rsp0", 32'(rsp0_valid), 32'd1);
        drive0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
